ex_pipe_ctrl: RTL and testbench

- Pipeline sequencing controller for the execute/memory path: ID/EX, EX/MEM and MEM/WB registers.
- Tracks per-stage valid and destination metadata, and detects load-use hazards, inserting one bubble.
- Drives the data-memory request/ready handshake and freezes the pipe while an access is pending.
- Flushes on taken branches and generates forwarding selects for the EX-stage operands (rs1 + imm address path, rs2 store data).

---
 rtl/ex_pipe_ctrl.sv | 249 ++++++++++++++++++++++++
 tb/tb_ex_pipe_ctrl.sv | 525 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_pipe_ctrl.sv
// ex_pipe_ctrl: sequencing controller for the ID/EX, EX/MEM and MEM/WB pipeline registers.
//
// Tracks per-stage valid bits and destination metadata, inserts one bubble on a
// load-use hazard, runs the data-memory request/ready handshake (freezing the
// front of the pipe while an access waits), flushes on taken branches and
// produces forwarding selects for the two EX-stage source operands.
//
// Ports:
//   clk, reset_n                      clock (rising edge), async active-low reset
//   id_valid, id_rs1, id_rs2,         instruction currently in ID: sources, usage,
//   id_uses_rs1, id_uses_rs2,         destination and memory-op type
//   id_rd, id_rd_we, id_is_load,
//   id_is_store
//   ex_branch_taken                   branch in EX resolved taken
//   mem_ready                         data memory completes the access this cycle
//   pc_en .. mem_wb_en                pipeline register enables
//   id_ex_bubble, flush_if_id         bubble into ID/EX, squash IF/ID
//   fwd_rs1_sel, fwd_rs2_sel          00 regfile, 01 EX/MEM, 10 MEM/WB
//   mem_req, mem_we, mem_err          memory request, store flag, timeout pulse
//   ex_valid, mem_valid, wb_valid     stage valid bits
//   stall_cycles                      saturating count of cycles with pc_en=0
module ex_pipe_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned PERF_W      = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              id_valid,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [4:0]        id_rd,
    input  logic              id_rd_we,
    input  logic              id_is_load,
    input  logic              id_is_store,
    input  logic              ex_branch_taken,
    input  logic              mem_ready,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              id_ex_en,
    output logic              ex_mem_en,
    output logic              mem_wb_en,
    output logic              id_ex_bubble,
    output logic              flush_if_id,
    output logic [1:0]        fwd_rs1_sel,
    output logic [1:0]        fwd_rs2_sel,
    output logic              mem_req,
    output logic              mem_we,
    output logic              mem_err,
    output logic              ex_valid,
    output logic              mem_valid,
    output logic              wb_valid,
    output logic [PERF_W-1:0] stall_cycles
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    // Last WAIT-cycle count value before the access is abandoned.
    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    // EX stage metadata
    logic              ex_valid_q;
    logic [4:0]        ex_rs1_q;
    logic [4:0]        ex_rs2_q;
    logic [4:0]        ex_rd_q;
    logic              ex_rd_we_q;
    logic              ex_load_q;
    logic              ex_store_q;
    // MEM stage metadata
    logic              mem_valid_q;
    logic [4:0]        mem_rd_q;
    logic              mem_rd_we_q;
    logic              mem_load_q;
    logic              mem_store_q;
    // WB stage metadata
    logic              wb_valid_q;
    logic [4:0]        wb_rd_q;
    logic              wb_rd_we_q;
    // Memory FSM and counters
    logic [0:0]        state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [PERF_W-1:0] stall_q;

    logic mem_op;
    logic mem_stall;
    logic load_use;
    logic branch_flush;
    logic ex_take;

    // ------------------------------------------------------------------
    // Memory handshake FSM
    // ------------------------------------------------------------------
    always_comb begin
        mem_op    = mem_valid_q & (mem_load_q | mem_store_q);
        mem_req   = 1'b0;
        mem_err   = 1'b0;
        mem_stall = 1'b0;
        state_d   = state_q;
        cnt_d     = cnt_q;
        case (state_q)
            ST_IDLE: begin
                mem_req = mem_op;
                if (mem_op && !mem_ready) begin
                    state_d   = ST_WAIT;
                    cnt_d     = 8'd0;
                    mem_stall = 1'b1;
                end
            end
            default: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    // Abandon the access: report it and let the pipe move on.
                    mem_err = 1'b1;
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    mem_stall = 1'b1;
                    cnt_d     = cnt_q + 8'd1;
                end
            end
        endcase
    end

    assign mem_we = mem_req & mem_store_q;

    // ------------------------------------------------------------------
    // Hazard detection and enables (mem stall > branch flush > load-use)
    // ------------------------------------------------------------------
    assign load_use = id_valid & ex_valid_q & ex_load_q & ex_rd_we_q & (ex_rd_q != 5'd0) &
                      ((id_uses_rs1 & (id_rs1 == ex_rd_q)) |
                       (id_uses_rs2 & (id_rs2 == ex_rd_q)));

    assign branch_flush = ex_valid_q & ex_branch_taken;

    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        id_ex_bubble = 1'b0;
        flush_if_id  = 1'b0;
        if (mem_stall) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
        end else if (branch_flush) begin
            flush_if_id  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (load_use) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Forwarding selects (EX/MEM result has priority over MEM/WB)
    // ------------------------------------------------------------------
    always_comb begin
        fwd_rs1_sel = 2'b00;
        fwd_rs2_sel = 2'b00;
        if (mem_valid_q && mem_rd_we_q && mem_rd_q != 5'd0 && mem_rd_q == ex_rs1_q) begin
            fwd_rs1_sel = 2'b01;
        end else if (wb_valid_q && wb_rd_we_q && wb_rd_q != 5'd0 && wb_rd_q == ex_rs1_q) begin
            fwd_rs1_sel = 2'b10;
        end
        if (mem_valid_q && mem_rd_we_q && mem_rd_q != 5'd0 && mem_rd_q == ex_rs2_q) begin
            fwd_rs2_sel = 2'b01;
        end else if (wb_valid_q && wb_rd_we_q && wb_rd_q != 5'd0 && wb_rd_q == ex_rs2_q) begin
            fwd_rs2_sel = 2'b10;
        end
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    // A bubble loads cleared metadata so stale fields can never match.
    assign ex_take = id_valid & ~id_ex_bubble;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_valid_q  <= 1'b0;
            ex_rs1_q    <= 5'd0;
            ex_rs2_q    <= 5'd0;
            ex_rd_q     <= 5'd0;
            ex_rd_we_q  <= 1'b0;
            ex_load_q   <= 1'b0;
            ex_store_q  <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_rd_q    <= 5'd0;
            mem_rd_we_q <= 1'b0;
            mem_load_q  <= 1'b0;
            mem_store_q <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= 5'd0;
            wb_rd_we_q  <= 1'b0;
        end else begin
            if (id_ex_en) begin
                ex_valid_q <= ex_take;
                ex_rs1_q   <= ex_take ? id_rs1 : 5'd0;
                ex_rs2_q   <= ex_take ? id_rs2 : 5'd0;
                ex_rd_q    <= ex_take ? id_rd : 5'd0;
                ex_rd_we_q <= ex_take & id_rd_we;
                ex_load_q  <= ex_take & id_is_load;
                ex_store_q <= ex_take & id_is_store;
            end
            if (ex_mem_en) begin
                mem_valid_q <= ex_valid_q;
                mem_rd_q    <= ex_rd_q;
                mem_rd_we_q <= ex_rd_we_q;
                mem_load_q  <= ex_load_q;
                mem_store_q <= ex_store_q;
            end
            if (mem_wb_en) begin
                // While MEM is held, WB receives a bubble instead of a duplicate.
                wb_valid_q <= mem_valid_q & ~mem_stall;
                wb_rd_q    <= mem_rd_q;
                wb_rd_we_q <= mem_rd_we_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (!pc_en && stall_q != '1) begin
                stall_q <= stall_q + 1'b1;
            end
        end
    end

    assign ex_valid     = ex_valid_q;
    assign mem_valid    = mem_valid_q;
    assign wb_valid     = wb_valid_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_ex_pipe_ctrl.sv
module tb_ex_pipe_ctrl;

    logic       clk;
    logic       reset_n;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_uses_rs1;
    logic       id_uses_rs2;
    logic [4:0] id_rd;
    logic       id_rd_we;
    logic       id_is_load;
    logic       id_is_store;
    logic       ex_branch_taken;
    logic       mem_ready;
    logic       pc_en;
    logic       if_id_en;
    logic       id_ex_en;
    logic       ex_mem_en;
    logic       mem_wb_en;
    logic       id_ex_bubble;
    logic       flush_if_id;
    logic [1:0] fwd_rs1_sel;
    logic [1:0] fwd_rs2_sel;
    logic       mem_req;
    logic       mem_we;
    logic       mem_err;
    logic       ex_valid;
    logic       mem_valid;
    logic       wb_valid;
    logic [3:0] stall_cycles;

    // {pc, if_id, id_ex, ex_mem, mem_wb, bubble, flush, req, we, err}
    logic [9:0] ctl;
    assign ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                  id_ex_bubble, flush_if_id, mem_req, mem_we, mem_err};

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int sb[$];
    bit sb_on       = 1'b1;

    ex_pipe_ctrl #(
        .MEM_TIMEOUT (4),
        .PERF_W      (4)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .id_rd           (id_rd),
        .id_rd_we        (id_rd_we),
        .id_is_load      (id_is_load),
        .id_is_store     (id_is_store),
        .ex_branch_taken (ex_branch_taken),
        .mem_ready       (mem_ready),
        .pc_en           (pc_en),
        .if_id_en        (if_id_en),
        .id_ex_en        (id_ex_en),
        .ex_mem_en       (ex_mem_en),
        .mem_wb_en       (mem_wb_en),
        .id_ex_bubble    (id_ex_bubble),
        .flush_if_id     (flush_if_id),
        .fwd_rs1_sel     (fwd_rs1_sel),
        .fwd_rs2_sel     (fwd_rs2_sel),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_err         (mem_err),
        .ex_valid        (ex_valid),
        .mem_valid       (mem_valid),
        .wb_valid        (wb_valid),
        .stall_cycles    (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Retirement scoreboard: each issued instruction pushed its expected WB cycle.
    always @(negedge clk) begin
        int exp_c;
        if (reset_n && sb_on && wb_valid) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL sb_retire: wb_valid at cycle %0d, no retirement expected", cyc);
            end else begin
                exp_c = sb.pop_front();
                if (cyc != exp_c) begin
                    miscompares++;
                    $display("FAIL sb_retire: retired at cycle %0d, expected cycle %0d", cyc, exp_c);
                end
            end
        end
        // A load in MEM must never feed a source of the valid instruction in EX.
        if (reset_n && dut.ex_valid_q && dut.mem_valid_q && dut.mem_load_q && dut.mem_rd_we_q &&
            dut.mem_rd_q != 5'd0 &&
            (dut.ex_rs1_q == dut.mem_rd_q || dut.ex_rs2_q == dut.mem_rd_q)) begin
            miscompares++;
            $display("FAIL load_in_mem_fwd: cycle %0d load rd x%0d feeds EX, required never",
                     cyc, dut.mem_rd_q);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic drive(input int v, input int rs1, input int rs2, input int u1, input int u2,
                         input int rd, input int we, input int ld, input int st);
        id_valid    = 1'(v);
        id_rs1      = 5'(rs1);
        id_rs2      = 5'(rs2);
        id_uses_rs1 = 1'(u1);
        id_uses_rs2 = 1'(u2);
        id_rd       = 5'(rd);
        id_rd_we    = 1'(we);
        id_is_load  = 1'(ld);
        id_is_store = 1'(st);
    endtask

    task automatic drive_nop();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive_nop();
        mem_ready       = 1'b1;
        ex_branch_taken = 1'b0;
        reset_n         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        sb.delete();
        sb_on = 1'b1;
    endtask

    task automatic test_reset();
        drive(1, 3, 4, 1, 1, 5, 1, 1, 0);
        mem_ready = 1'b0;
        reset_n   = 1'b0;
        #2;
        vectors++;
        if (ctl !== 10'b1111100000) begin
            miscompares++;
            $display("FAIL reset_ctl: got %b want 1111100000", ctl);
        end
        vectors++;
        if ({fwd_rs1_sel, fwd_rs2_sel} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_fwd: got %b want 0000", {fwd_rs1_sel, fwd_rs2_sel});
        end
        vectors++;
        if ({ex_valid, mem_valid, wb_valid} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_valid: got %b want 000", {ex_valid, mem_valid, wb_valid});
        end
        vectors++;
        if (stall_cycles !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_stall: got %0d want 0", stall_cycles);
        end
        do_reset();
    endtask

    task automatic test_independent();
        logic [2:0] ev;
        do_reset();
        for (int i = 0; i < 14; i++) begin
            if (i < 10) begin
                drive(1, 20 + (i % 5), 21, 1, 0, i + 1, 1, 0, 0);
                sb.push_back(cyc + 3);
            end else begin
                drive_nop();
            end
            @(negedge clk);
            ev = {(i >= 1 && i <= 10), (i >= 2 && i <= 11), (i >= 3 && i <= 12)};
            vectors++;
            if (ctl !== 10'b1111100000) begin
                miscompares++;
                $display("FAIL indep_ctl c%0d: got %b want 1111100000", i, ctl);
            end
            vectors++;
            if ({ex_valid, mem_valid, wb_valid} !== ev) begin
                miscompares++;
                $display("FAIL indep_valid c%0d: got %b want %b", i,
                         {ex_valid, mem_valid, wb_valid}, ev);
            end
            vectors++;
            if ({fwd_rs1_sel, fwd_rs2_sel} !== 4'b0000) begin
                miscompares++;
                $display("FAIL indep_fwd c%0d: got %b want 0000", i, {fwd_rs1_sel, fwd_rs2_sel});
            end
            next();
        end
        vectors++;
        if (stall_cycles !== 4'd0) begin
            miscompares++;
            $display("FAIL indep_stall: got %0d want 0", stall_cycles);
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL indep_drain: %0d retirements missing, want 0", sb.size());
        end
    endtask

    task automatic test_load_use();
        logic [9:0] e [4];
        e = '{10'b1111100000, 10'b0011110000, 10'b1111100100, 10'b1111100000};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            case (i)
                0: begin drive(1, 1, 0, 1, 0, 5, 1, 1, 0); sb.push_back(cyc + 3); end
                1: drive(1, 5, 0, 1, 0, 6, 1, 0, 0);
                2: begin drive(1, 5, 0, 1, 0, 6, 1, 0, 0); sb.push_back(cyc + 3); end
                default: drive_nop();
            endcase
            @(negedge clk);
            if (i < 4) begin
                vectors++;
                if (ctl !== e[i]) begin
                    miscompares++;
                    $display("FAIL load_use_ctl c%0d: got %b want %b", i, ctl, e[i]);
                end
            end
            if (i == 3) begin
                vectors++;
                if ({fwd_rs1_sel, fwd_rs2_sel} !== 4'b1000) begin
                    miscompares++;
                    $display("FAIL load_use_fwd: got %b want 1000", {fwd_rs1_sel, fwd_rs2_sel});
                end
            end
            if (i == 4) begin
                vectors++;
                if (stall_cycles !== 4'd1) begin
                    miscompares++;
                    $display("FAIL load_use_stall: got %0d want 1", stall_cycles);
                end
            end
            next();
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL load_use_drain: %0d retirements missing, want 0", sb.size());
        end
    endtask

    task automatic test_store_wait();
        logic [9:0] e [7];
        e = '{10'b1111100000, 10'b1111100000, 10'b0000100110, 10'b0000100110,
              10'b0000100110, 10'b1111100110, 10'b1111100000};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            mem_ready = (i >= 2 && i <= 4) ? 1'b0 : 1'b1;
            case (i)
                0: begin drive(1, 2, 3, 1, 1, 0, 0, 0, 1); sb.push_back(cyc + 6); end
                1: begin drive(1, 0, 0, 0, 0, 7, 1, 0, 0); sb.push_back(cyc + 6); end
                2, 3, 4: drive(1, 0, 0, 0, 0, 8, 1, 0, 0);
                5: begin drive(1, 0, 0, 0, 0, 8, 1, 0, 0); sb.push_back(cyc + 3); end
                default: drive_nop();
            endcase
            @(negedge clk);
            if (i < 7) begin
                vectors++;
                if (ctl !== e[i]) begin
                    miscompares++;
                    $display("FAIL store_wait_ctl c%0d: got %b want %b", i, ctl, e[i]);
                end
            end
            if (i >= 3 && i <= 5) begin
                vectors++;
                if (wb_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL store_wait_wb_bubble c%0d: got %b want 0", i, wb_valid);
                end
            end
            if (i == 6) begin
                vectors++;
                if (stall_cycles !== 4'd3) begin
                    miscompares++;
                    $display("FAIL store_wait_stall: got %0d want 3", stall_cycles);
                end
            end
            next();
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL store_wait_drain: %0d retirements missing, want 0", sb.size());
        end
    endtask

    task automatic test_timeout();
        logic [9:0] e [8];
        e = '{10'b1111100000, 10'b1111100000, 10'b0000100100, 10'b0000100100,
              10'b0000100100, 10'b0000100100, 10'b1111100101, 10'b1111100000};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            mem_ready = (i < 8) ? 1'b0 : 1'b1;
            case (i)
                0: begin drive(1, 0, 0, 0, 0, 9, 1, 1, 0); sb.push_back(cyc + 7); end
                1: begin drive(1, 0, 0, 0, 0, 10, 1, 0, 0); sb.push_back(cyc + 7); end
                default: drive_nop();
            endcase
            @(negedge clk);
            if (i < 8) begin
                vectors++;
                if (ctl !== e[i]) begin
                    miscompares++;
                    $display("FAIL timeout_ctl c%0d: got %b want %b", i, ctl, e[i]);
                end
            end
            if (i == 7) begin
                vectors++;
                if (stall_cycles !== 4'd4) begin
                    miscompares++;
                    $display("FAIL timeout_stall: got %0d want 4", stall_cycles);
                end
            end
            next();
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL timeout_drain: %0d retirements missing, want 0", sb.size());
        end
    endtask

    task automatic test_branch_flush();
        logic [9:0] e [8];
        e = '{10'b1111100000, 10'b1111111000, 10'b1111100100, 10'b1111100000,
              10'b1111100000, 10'b0000100110, 10'b1111111110, 10'b1111100000};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            mem_ready       = (i == 5) ? 1'b0 : 1'b1;
            ex_branch_taken = (i == 1 || i == 5 || i == 6) ? 1'b1 : 1'b0;
            case (i)
                0: begin drive(1, 1, 0, 1, 0, 5, 1, 1, 0); sb.push_back(cyc + 3); end
                1: drive(1, 5, 0, 1, 0, 6, 1, 0, 0);
                3: begin drive(1, 2, 0, 1, 0, 0, 0, 0, 1); sb.push_back(cyc + 4); end
                4: begin drive(1, 0, 0, 0, 0, 0, 0, 0, 0); sb.push_back(cyc + 4); end
                5, 6: drive(1, 0, 0, 0, 0, 11, 1, 0, 0);
                default: drive_nop();
            endcase
            @(negedge clk);
            if (i < 8) begin
                vectors++;
                if (ctl !== e[i]) begin
                    miscompares++;
                    $display("FAIL branch_ctl c%0d: got %b want %b", i, ctl, e[i]);
                end
            end
            if (i == 2 || i == 7) begin
                vectors++;
                if (ex_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL branch_ex_squashed c%0d: got %b want 0", i, ex_valid);
                end
            end
            if (i == 2) begin
                vectors++;
                if (stall_cycles !== 4'd0) begin
                    miscompares++;
                    $display("FAIL branch_no_load_use_stall: got %0d want 0", stall_cycles);
                end
            end
            if (i == 8) begin
                vectors++;
                if (stall_cycles !== 4'd1) begin
                    miscompares++;
                    $display("FAIL branch_mem_stall: got %0d want 1", stall_cycles);
                end
            end
            next();
        end
        ex_branch_taken = 1'b0;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL branch_drain: %0d retirements missing, want 0", sb.size());
        end
    endtask

    task automatic test_forwarding();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            case (i)
                0, 1: begin drive(1, 0, 0, 0, 0, 3, 1, 0, 0); sb.push_back(cyc + 3); end
                2: begin drive(1, 3, 3, 1, 1, 0, 1, 0, 0); sb.push_back(cyc + 3); end
                3: begin drive(1, 0, 3, 1, 1, 4, 1, 0, 0); sb.push_back(cyc + 3); end
                default: drive_nop();
            endcase
            @(negedge clk);
            if (i == 3) begin
                vectors++;
                if ({fwd_rs1_sel, fwd_rs2_sel} !== 4'b0101) begin
                    miscompares++;
                    $display("FAIL fwd_mem_priority: got %b want 0101",
                             {fwd_rs1_sel, fwd_rs2_sel});
                end
            end
            if (i == 4) begin
                vectors++;
                if ({fwd_rs1_sel, fwd_rs2_sel} !== 4'b0010) begin
                    miscompares++;
                    $display("FAIL fwd_wb_and_x0: got %b want 0010", {fwd_rs1_sel, fwd_rs2_sel});
                end
            end
            next();
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL fwd_drain: %0d retirements missing, want 0", sb.size());
        end
    endtask

    task automatic test_reset_wait();
        do_reset();
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) drive(1, 0, 0, 0, 0, 4, 1, 1, 0);
            else drive_nop();
            @(negedge clk);
            if (i == 3) begin
                vectors++;
                if ({mem_req, stall_cycles} !== {1'b1, 4'd1}) begin
                    miscompares++;
                    $display("FAIL rst_wait_pre: req/stall got %b/%0d want 1/1", mem_req,
                             stall_cycles);
                end
            end
            if (i < 3) next();
        end
        #1;
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({mem_req, ex_valid, mem_valid, wb_valid, stall_cycles} !== 8'b0000_0000) begin
            miscompares++;
            $display("FAIL rst_wait_async: req/valids/stall got %b want 00000000",
                     {mem_req, ex_valid, mem_valid, wb_valid, stall_cycles});
        end
        #1;
        reset_n = 1'b1;
        sb.delete();
        next();
        for (int i = 0; i < 7; i++) begin
            mem_ready = (i < 3) ? 1'b0 : 1'b1;
            if (i == 3) begin
                drive(1, 0, 0, 0, 0, 3, 1, 1, 0);
                sb.push_back(cyc + 3);
            end else begin
                drive_nop();
            end
            @(negedge clk);
            vectors++;
            if (ctl !== ((i == 5) ? 10'b1111100100 : 10'b1111100000)) begin
                miscompares++;
                $display("FAIL rst_wait_after c%0d: got %b want %b", i, ctl,
                         (i == 5) ? 10'b1111100100 : 10'b1111100000);
            end
            next();
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL rst_wait_drain: %0d retirements missing, want 0", sb.size());
        end
    endtask

    task automatic test_saturation();
        do_reset();
        sb_on     = 1'b0;
        mem_ready = 1'b0;
        for (int i = 0; i < 30; i++) begin
            drive(1, 0, 0, 0, 0, 1, 1, 1, 0);
            next();
        end
        drive_nop();
        mem_ready = 1'b1;
        repeat (4) next();
        @(negedge clk);
        vectors++;
        if (stall_cycles !== 4'hf) begin
            miscompares++;
            $display("FAIL stall_saturate: got %0d want 15", stall_cycles);
        end
        next();
    endtask

    initial begin
        reset_n         = 1'b0;
        mem_ready       = 1'b1;
        ex_branch_taken = 1'b0;
        drive_nop();
        #12;
        test_reset();
        test_independent();
        test_load_use();
        test_store_wait();
        test_timeout();
        test_branch_flush();
        test_forwarding();
        test_reset_wait();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
